// File: rtl/uart_pkg.sv
// uart_pkg: constants and FSM state encodings shared by the UART RX and TX paths
package uart_pkg;
    localparam int DATA_BITS = 8;
    localparam int CLKS_PER_BIT_DEF = 434;
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t START = 2'd1;
    localparam state_t DATA  = 2'd2;
    localparam state_t STOP  = 2'd3;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer and falling-edge detector for the RX line
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rx_s,
    output logic fall
);
    logic s1, s2, prev, armed;
    logic [1:0] live;
    // armed waits until a real post-reset high has reached s2, so a line held low
    // through reset release cannot fake a falling edge against the reset-high flops
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            prev  <= 1'b1;
            live  <= 2'b00;
            armed <= 1'b0;
        end else begin
            s1    <= rx_in;
            s2    <= s1;
            prev  <= s2;
            live  <= {live[0], 1'b1};
            armed <= armed | (live[1] & s2);
        end
    end
    assign rx_s = s2;
    assign fall = armed & prev & ~s2;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver with mid-bit sampling and one-cycle strobes
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] dout,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic rx_s, fall;
    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [DATA_BITS-1:0] shreg;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx_in(rx_in),
        .rx_s (rx_s),
        .fall (fall)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            dout      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= rx_s;
                        idx        <= idx + 1'b1;
                        state      <= (idx == LAST_BIT) ? STOP : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        state     <= IDLE;
                        rx_valid  <= rx_s;
                        frame_err <= ~rx_s;
                        if (rx_s) dout <= shreg;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign rx_busy = (state != IDLE);
endmodule
